// File: rtl/comparator_serial.sv
// Serial magnitude comparator: compares two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, stopping at the first differing digit.
// Signed mode flips the sign bit of both operands (offset binary), so the
// serial compare itself is always unsigned.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request a compare (sampled only while idle)
//   signed_mode  1 = two's-complement compare, 0 = unsigned (sampled with start)
//   a, b         operands (sampled with start)
//   busy         high while a compare is running
//   done         one-cycle pulse when new flags are valid
//   a_gt_b, a_lt_b, a_eq_b  registered result, held until the next result
module comparator_serial #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             a_eq_b
);

    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_gt;
    logic               r_lt;
    logic               r_eq;

    logic [DIGIT-1:0]   w_da;
    logic [DIGIT-1:0]   w_db;
    logic [WIDTH-1:0]   w_flip;

    // Top digit of each shift register is the one under comparison
    assign w_da   = r_sa[WIDTH-1 -: DIGIT];
    assign w_db   = r_sb[WIDTH-1 -: DIGIT];
    assign w_flip = signed_mode ? MSB_MASK : '0;

    // Control FSM and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa    <= a ^ w_flip;
                        r_sb    <= b ^ w_flip;
                        r_idx   <= IDX_W'(NDIG - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_da > w_db) begin
                        r_gt    <= 1'b1;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_da < w_db) begin
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b1;
                        r_eq    <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_idx == '0) begin
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // Digits equal so far: expose the next digit
                        r_sa  <= r_sa << DIGIT;
                        r_sb  <= r_sb << DIGIT;
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign a_gt_b = r_gt;
    assign a_lt_b = r_lt;
    assign a_eq_b = r_eq;

endmodule

// File: tb/tb_comparator_serial.sv
// Self-checking bench for comparator_serial: an 8-bit/2-bit-digit instance
// and a 3-bit/1-bit-digit instance, checked against directed vectors, a
// few hand-written multi-cycle sequences and an arithmetic reference model.
module tb_comparator_serial;

    logic       clk;
    logic       rst_n;
    logic       start8;
    logic       start3;
    logic       sm_in;
    logic [7:0] a_in;
    logic [7:0] b_in;

    logic busy8, done8, gt8, lt8, eq8;
    logic busy3, done3, gt3, lt3, eq3;

    int n_checks = 0;
    int n_err    = 0;

    comparator_serial #(.WIDTH(8), .DIGIT(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm_in),
        .a(a_in), .b(b_in), .busy(busy8), .done(done8),
        .a_gt_b(gt8), .a_lt_b(lt8), .a_eq_b(eq8)
    );

    comparator_serial #(.WIDTH(3), .DIGIT(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .signed_mode(sm_in),
        .a(a_in[2:0]), .b(b_in[2:0]), .busy(busy3), .done(done3),
        .a_gt_b(gt3), .a_lt_b(lt3), .a_eq_b(eq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic [2:0] fl;   // {gt, lt, eq}
        int         lat;
    } vec_t;

    logic       sel;
    logic       busy_m, done_m;
    logic [2:0] flags_m;
    assign busy_m  = sel ? busy3 : busy8;
    assign done_m  = sel ? done3 : done8;
    assign flags_m = sel ? {gt3, lt3, eq3} : {gt8, lt8, eq8};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer compare plus first-differing-digit search
    function automatic void model(input bit s, input logic [7:0] av, input logic [7:0] bv,
                                  input logic sm, output logic [2:0] fl, output int lat);
        int w  = s ? 3 : 8;
        int d  = s ? 1 : 2;
        int ai = int'(av) & ((1 << w) - 1);
        int bi = int'(bv) & ((1 << w) - 1);
        int x  = ai;
        int y  = bi;
        int m  = (1 << d) - 1;
        int nd = w / d;
        if (sm) begin
            if (x >= (1 << (w - 1))) x -= (1 << w);
            if (y >= (1 << (w - 1))) y -= (1 << w);
        end
        fl  = (x > y) ? 3'b100 : ((x < y) ? 3'b010 : 3'b001);
        lat = nd;
        for (int k = 1; k <= nd; k++) begin
            if (((ai >> (w - k * d)) & m) != ((bi >> (w - k * d)) & m)) begin
                lat = k;
                break;
            end
        end
    endfunction

    // One full compare on the selected instance, checking latency, busy,
    // flag hold during RUN, result and single-cycle done
    task automatic run_cmp(input bit s, input logic [7:0] av, input logic [7:0] bv,
                           input logic sm, input logic [2:0] efl, input int elat,
                           input string name);
        logic [2:0] prev;
        int cyc;
        sel = s;
        @(negedge clk);
        a_in = av; b_in = bv; sm_in = sm;
        if (s) start3 = 1'b1; else start8 = 1'b1;
        prev = flags_m;
        @(posedge clk); #1;
        start8 = 1'b0; start3 = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); sm_in = 1'($urandom);
        chk({name, " busy_e0"}, int'(busy_m), 1);
        chk({name, " done_e0"}, int'(done_m), 0);
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done_m) begin
                cyc = c;
                break;
            end
            if (busy_m !== 1'b1 || flags_m !== prev)
                chk({name, " run_state"}, int'({busy_m, flags_m}), int'({1'b1, prev}));
        end
        chk({name, " latency"}, cyc, elat);
        chk({name, " flags"}, int'(flags_m), int'(efl));
        chk({name, " busy_done"}, int'(busy_m), 0);
        @(posedge clk); #1;
        chk({name, " done_pulse"}, int'(done_m), 0);
        chk({name, " flags_hold"}, int'(flags_m), int'(efl));
    endtask

    vec_t vecs[$];

    initial begin
        logic [2:0] fl;
        int lat;
        int cyc;

        vecs.push_back('{8'hC0, 8'h3F, 1'b0, 3'b100, 1});
        vecs.push_back('{8'h3F, 8'h40, 1'b0, 3'b010, 1});
        vecs.push_back('{8'h5A, 8'h5A, 1'b0, 3'b001, 4});
        vecs.push_back('{8'h5A, 8'h5A, 1'b1, 3'b001, 4});
        vecs.push_back('{8'h80, 8'h01, 1'b1, 3'b010, 1});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 3'b100, 1});
        vecs.push_back('{8'hFF, 8'hFE, 1'b1, 3'b100, 4});
        vecs.push_back('{8'h00, 8'hFF, 1'b1, 3'b100, 1});
        vecs.push_back('{8'h7F, 8'h80, 1'b1, 3'b100, 1});
        vecs.push_back('{8'h5A, 8'h5B, 1'b0, 3'b010, 4});
        vecs.push_back('{8'h12, 8'h1F, 1'b0, 3'b010, 3});
        vecs.push_back('{8'hA5, 8'hA4, 1'b0, 3'b100, 4});

        sel = 1'b0;
        rst_n = 1'b0; start8 = 1'b0; start3 = 1'b0;
        sm_in = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset8 outs", int'({busy8, done8, gt8, lt8, eq8}), 0);
        chk("reset3 outs", int'({busy3, done3, gt3, lt3, eq3}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        foreach (vecs[i])
            run_cmp(1'b0, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].fl, vecs[i].lat,
                    $sformatf("vec%0d", i));

        // start pulsed during RUN must not resample operands
        sel = 1'b0;
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h5B; sm_in = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin a_in = 8'hFF; b_in = 8'h00; start8 = 1'b1; end
            if (c == 2) start8 = 1'b0;
            @(posedge clk); #1;
            if (done8) begin cyc = c; break; end
        end
        chk("ignore_start latency", cyc, 4);
        chk("ignore_start flags", int'({gt8, lt8, eq8}), int'(3'b010));
        @(posedge clk); #1;
        chk("ignore_start idle", int'({busy8, done8}), 0);

        // start held high: second compare accepted in the done cycle
        @(negedge clk);
        a_in = 8'hC0; b_in = 8'h3F; start8 = 1'b1;
        @(posedge clk); #1;
        chk("b2b busy_e0", int'(busy8), 1);
        @(posedge clk); #1;
        chk("b2b done1", int'(done8), 1);
        chk("b2b flags1", int'({gt8, lt8, eq8}), int'(3'b100));
        a_in = 8'h12; b_in = 8'h1F;
        @(posedge clk); #1;
        chk("b2b restart", int'({busy8, done8}), int'(2'b10));
        start8 = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (done8) begin cyc = c; break; end
        end
        chk("b2b latency2", cyc, 3);
        chk("b2b flags2", int'({gt8, lt8, eq8}), int'(3'b010));

        // Reset in the middle of a RUN: immediate clear, no done afterwards
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h5A; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun reset outs", int'({busy8, done8, gt8, lt8, eq8}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("midrun no_done", int'({busy8, done8}), 0);
        end

        // Randomised 8-bit compares against the model
        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? ra ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            if (i % 10 == 0) rb = ra;
            rs = 1'($urandom);
            model(1'b0, ra, rb, rs, fl, lat);
            run_cmp(1'b0, ra, rb, rs, fl, lat, $sformatf("rand%0d", i));
        end

        // Exhaustive 3-bit / 1-bit-digit instance in both modes
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++) begin
                    model(1'b1, 8'(x), 8'(y), 1'(m), fl, lat);
                    run_cmp(1'b1, 8'(x), 8'(y), 1'(m), fl, lat,
                            $sformatf("w3 m%0d a%0d b%0d", m, x, y));
                end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
